// File: rtl/mem_access_unit.sv
// Memory-stage controller: issues one load/store per EX/MEM instruction over a req/ack
// handshake, stalls the pipeline while it is in flight, and aborts via a watchdog.
module mem_access_unit #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ex_valid,
  input  logic              i_ex_memread,
  input  logic              i_ex_memwrite,
  input  logic [ADDR_W-1:0] i_ex_addr,
  input  logic [DATA_W-1:0] i_ex_wdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_stall,
  output logic              o_wb_valid,
  output logic [DATA_W-1:0] o_wb_rdata,
  output logic              o_err
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                r_wb_valid, w_wb_valid_nxt;
  logic [DATA_W-1:0]   r_wb_rdata, w_wb_rdata_nxt;
  logic                r_err, w_err_nxt;
  logic                w_access;
  logic                w_timeout;

  assign w_access  = i_ex_valid & (i_ex_memread | i_ex_memwrite);
  assign w_timeout = (r_cnt == CNT_W'(MAX_WAIT - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_wb_valid_nxt  = 1'b0;
    w_wb_rdata_nxt  = r_wb_rdata;
    w_err_nxt       = 1'b0;
    o_stall         = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (w_access) begin
          o_stall         = 1'b1;
          w_mem_addr_nxt  = i_ex_addr;
          w_mem_wdata_nxt = i_ex_wdata;
          // A store wins when both read and write are flagged.
          w_mem_we_nxt    = i_ex_memwrite;
          w_mem_req_nxt   = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = StBusy;
        end
      end
      StBusy: begin
        o_stall = 1'b1;
        if (i_mem_ack) begin
          w_mem_req_nxt = 1'b0;
          if (!r_mem_we) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_rdata_nxt = i_mem_rdata;
          end
          w_state_nxt = StDone;
        end else if (w_timeout) begin
          w_mem_req_nxt = 1'b0;
          w_err_nxt     = 1'b1;
          if (!r_mem_we) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_rdata_nxt = '0;
          end
          w_state_nxt = StDone;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      // Pipeline advances this cycle; the still-visible ex_* slot must not re-issue.
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rdata  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_wb_rdata  <= w_wb_rdata_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_wb_valid  = r_wb_valid;
  assign o_wb_rdata  = r_wb_rdata;
  assign o_err       = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized accesses
// checked against a transaction-level model of latency, abort and write-back behaviour.
module tb_mem_access_unit;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid, ex_memread, ex_memwrite;
  logic [AW-1:0] ex_addr;
  logic [DW-1:0] ex_wdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall, wb_valid, err;
  logic [DW-1:0] wb_rdata;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] model_wb;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ex_valid    (ex_valid),
    .i_ex_memread  (ex_memread),
    .i_ex_memwrite (ex_memwrite),
    .i_ex_addr     (ex_addr),
    .i_ex_wdata    (ex_wdata),
    .o_mem_req     (mem_req),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_ack     (mem_ack),
    .i_mem_rdata   (mem_rdata),
    .o_stall       (stall),
    .o_wb_valid    (wb_valid),
    .o_wb_rdata    (wb_rdata),
    .o_err         (err)
  );

  // Runs one instruction through the memory stage. ack_at = BUSY cycle index (1-based) that
  // gets mem_ack; values above MW never ack. Inputs are held until the pipeline advances.
  task automatic run_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int ack_at,
                            input logic [DW-1:0] rdata, input string tag);
    int            busy, stalls, reqs, rises, wbv, errs, cyc, exp_busy;
    bit            bad_hold, wb_in_done, prev_req, fin, acked, is_rd;
    logic [DW-1:0] wb_seen;
    busy = 0; stalls = 0; reqs = 0; rises = 0; wbv = 0; errs = 0; cyc = 0;
    bad_hold = 0; wb_in_done = 1; prev_req = 0; fin = 0; wb_seen = '0;
    is_rd    = rd & ~wr;
    acked    = (ack_at >= 1) && (ack_at <= MW);
    exp_busy = acked ? ack_at : MW;
    while (!fin && cyc < 60) begin
      @(negedge clk);
      ex_valid = 1'b1; ex_memread = rd; ex_memwrite = wr; ex_addr = addr; ex_wdata = wdata;
      mem_ack = 1'b0; mem_rdata = DW'($urandom);
      if (mem_req) begin
        busy++;
        if (busy == ack_at) begin mem_ack = 1'b1; mem_rdata = rdata; end
      end
      #1;
      if (stall) stalls++;
      if (mem_req) begin
        reqs++;
        if (!prev_req) rises++;
        if (mem_we !== wr || mem_addr !== addr || mem_wdata !== wdata) bad_hold = 1;
      end
      prev_req = mem_req;
      if (wb_valid) begin wbv++; wb_seen = wb_rdata; if (stall) wb_in_done = 0; end
      if (err) errs++;
      if (!stall && stalls > 0) fin = 1;
      cyc++;
    end
    if (is_rd) model_wb = acked ? rdata : '0;

    n_checks++;
    if (!fin) $display("FAIL %s completion: stall never released within %0d cycles", tag, cyc);
    else n_pass++;
    n_checks++;
    if (reqs !== exp_busy) $display("FAIL %s req_cycles: got %0d want %0d", tag, reqs, exp_busy);
    else n_pass++;
    n_checks++;
    if (rises !== 1) $display("FAIL %s req_pulses: got %0d want 1", tag, rises);
    else n_pass++;
    n_checks++;
    if (stalls !== exp_busy + 1)
      $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, exp_busy + 1);
    else n_pass++;
    n_checks++;
    if (errs !== (acked ? 0 : 1)) $display("FAIL %s err_pulses: got %0d want %0d", tag, errs,
                                           acked ? 0 : 1);
    else n_pass++;
    n_checks++;
    if (wbv !== int'(is_rd)) $display("FAIL %s wb_valid_pulses: got %0d want %0d", tag, wbv,
                                      int'(is_rd));
    else n_pass++;
    n_checks++;
    if (!wb_in_done) $display("FAIL %s wb_valid_timing: got pulse while stalled want DONE", tag);
    else n_pass++;
    n_checks++;
    if (bad_hold) $display("FAIL %s mem_bus_hold: got changed we/addr/wdata want %0b/%h/%h",
                           tag, wr, addr, wdata);
    else n_pass++;
    n_checks++;
    if (wb_rdata !== model_wb) $display("FAIL %s wb_rdata: got %h want %h", tag, wb_rdata,
                                        model_wb);
    else n_pass++;
    if (is_rd) begin
      n_checks++;
      if (wb_seen !== model_wb) $display("FAIL %s wb_pulse_data: got %h want %h", tag, wb_seen,
                                         model_wb);
      else n_pass++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
      mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_addr = '0; ex_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_wb = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_rdata, err, stall} !== '0)
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h wbv=%b wbd=%h err=%b st=%b want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_rdata, err, stall);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_access(1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF, "t1_load_fast");
    idle_cycles(1);
    run_access(1'b0, 1'b1, 16'h0010, 16'h1234, 4, 16'h5555, "t2_store");
    idle_cycles(1);
    run_access(1'b1, 1'b0, 16'h0020, 16'h0000, 0, 16'h0000, "t3_timeout");
    idle_cycles(1);
    run_access(1'b1, 1'b0, 16'h0030, 16'h0000, MW, 16'h00A5, "t4_ack_at_limit");
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 16'h0100, 16'h0000, 1, 16'h1111, "t5_b2b_first");
    run_access(1'b1, 1'b0, 16'h0102, 16'h0000, 1, 16'h2222, "t5_b2b_second");
    idle_cycles(1);
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    ex_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    n_checks++;
    if (wb_valid !== 1'b0 || wb_rdata !== model_wb || mem_req !== 1'b0)
      $display("FAIL stray_ack_idle: got wbv=%b wbd=%h req=%b want 0/%h/0", wb_valid, wb_rdata,
               mem_req, model_wb);
    else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b1;
    ex_addr = 16'h0ABC; ex_wdata = 16'h7777; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (mem_req !== 1'b1) $display("FAIL t6_pre_reset_req: got %b want 1", mem_req);
    else n_pass++;
    #1;
    rst_n = 1'b0; ex_valid = 1'b0;
    model_wb = '0;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_rdata, err, stall} !== '0)
      $display("FAIL t6_async_reset: got req=%b we=%b addr=%h wd=%h wbv=%b err=%b st=%b want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, wb_valid, err, stall);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hFACE;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    n_checks++;
    if (wb_valid !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0 || wb_rdata !== 16'h0000)
      $display("FAIL t6_late_ack: got wbv=%b err=%b req=%b wbd=%h want 0/0/0/0000",
               wb_valid, err, mem_req, wb_rdata);
    else n_pass++;
    run_access(1'b1, 1'b1, 16'h0ABC, 16'h7777, 2, 16'h0000, "t6_reissue_as_write");
    idle_cycles(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      int            k;
      int            ack_at;
      logic [AW-1:0] a;
      logic [DW-1:0] w;
      logic [DW-1:0] r;
      k      = $urandom_range(1, 3);
      ack_at = $urandom_range(1, MW + 2);
      a      = AW'($urandom);
      w      = DW'($urandom);
      r      = DW'($urandom);
      run_access(k[0], k[1], a, w, ack_at, r, $sformatf("rand%0d", i));
      idle_cycles($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stray_ack();
    test_reset_mid_access();
    test_random();
    idle_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
